// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types, the AddRoundKey FSM encoding and a column
//               extract helper. Optional feature macro: KEY_ZEROIZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        ARKE_IDLE = 2'd0,
        ARKE_RUN  = 2'd1,
        ARKE_DONE = 2'd2
`ifdef KEY_ZEROIZE_EN
        , ARKE_ZERO = 2'd3
`endif
    } arke_state_e;

    // Column 0 occupies the most significant word.
    function automatic word_t col_get(input state_t i_s, input logic [1:0] i_c);
        return i_s[127 - 32*int'(i_c) -: 32];
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_round_key_column.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key_column
// Description : Combinational XOR of one 32-bit state column with its key column.
// Revision    : 1.0 - initial release
// ============================================================================
module add_round_key_column
    import aes_pkg::*;
(
    input  word_t i_col,
    input  word_t i_key,
    output word_t o_col
);

    assign o_col = i_col ^ i_key;

endmodule
`default_nettype wire

// File: rtl/add_round_key_engine.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key_engine
// Description : Multi-cycle AES (Inv)AddRoundKey with on-chip round-key store.
//               Optional feature macro: KEY_ZEROIZE_EN (zeroize port/ZERO state).
// Revision    : 1.0 - initial release
// ============================================================================
module add_round_key_engine
    import aes_pkg::*;
#(
    parameter int WORDS_PER_CYCLE = 1,
    parameter int NUM_KEYS        = 11,
    parameter int KEY_IDX_W       = $clog2(NUM_KEYS)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_key_we,
    input  logic [KEY_IDX_W-1:0] i_key_waddr,
    input  state_t               i_key_wdata,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  state_t               i_in_state,
    input  logic [KEY_IDX_W-1:0] i_in_key_idx,
    input  logic                 i_in_inverse,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output state_t               o_out_state,
    output logic                 o_out_err,
`ifdef KEY_ZEROIZE_EN
    input  logic                 i_zeroize,
`endif
    output logic                 o_busy
);

    localparam int BEATS  = 4 / WORDS_PER_CYCLE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KEY_IDX_W-1:0] c_last_key  = KEY_IDX_W'(NUM_KEYS - 1);
    localparam logic [BEAT_W-1:0]    c_last_beat = BEAT_W'(BEATS - 1);

    arke_state_e          r_state;
    state_t               r_keys [NUM_KEYS];
    state_t               r_work;
    state_t               r_wkey;
    logic                 r_err;
    logic [BEAT_W-1:0]    r_beat;
`ifdef KEY_ZEROIZE_EN
    logic [KEY_IDX_W-1:0] r_zidx;
`endif

    logic                 w_oob;
    logic [KEY_IDX_W-1:0] w_eff_idx;
    logic [1:0]           w_col [WORDS_PER_CYCLE];
    word_t                w_xor [WORDS_PER_CYCLE];

    // Range check happens on the raw index so the inverse subtraction never wraps into a legal slot.
    assign w_oob     = i_in_key_idx > c_last_key;
    assign w_eff_idx = i_in_inverse ? (c_last_key - i_in_key_idx) : i_in_key_idx;

    for (genvar g = 0; g < WORDS_PER_CYCLE; g++) begin : g_col
        assign w_col[g] = 2'(int'(r_beat) * WORDS_PER_CYCLE + g);
        add_round_key_column u_col (
            .i_col (col_get(r_work, w_col[g])),
            .i_key (col_get(r_wkey, w_col[g])),
            .o_col (w_xor[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_keys[k] <= '0;
            end
        end else begin
`ifdef KEY_ZEROIZE_EN
            if (r_state == ARKE_ZERO) begin
                r_keys[r_zidx] <= '0;
            end else
`endif
            if (i_key_we && (i_key_waddr <= c_last_key)) begin
                r_keys[i_key_waddr] <= i_key_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARKE_IDLE;
            r_work  <= '0;
            r_wkey  <= '0;
            r_err   <= 1'b0;
            r_beat  <= '0;
`ifdef KEY_ZEROIZE_EN
            r_zidx  <= '0;
`endif
        end else begin
            case (r_state)
                ARKE_IDLE: begin
`ifdef KEY_ZEROIZE_EN
                    if (i_zeroize) begin
                        r_zidx  <= '0;
                        r_state <= ARKE_ZERO;
                    end else
`endif
                    if (i_in_valid) begin
                        r_work  <= i_in_state;
                        r_wkey  <= w_oob ? '0 : r_keys[w_eff_idx];
                        r_err   <= w_oob;
                        r_beat  <= '0;
                        r_state <= ARKE_RUN;
                    end
                end
                ARKE_RUN: begin
                    for (int w = 0; w < WORDS_PER_CYCLE; w++) begin
                        r_work[127 - 32*int'(w_col[w]) -: 32] <= w_xor[w];
                    end
                    if (r_beat == c_last_beat) begin
                        r_state <= ARKE_DONE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                ARKE_DONE: begin
                    if (i_out_ready) begin
                        r_state <= ARKE_IDLE;
                    end
                end
`ifdef KEY_ZEROIZE_EN
                ARKE_ZERO: begin
                    if (r_zidx == c_last_key) begin
                        r_state <= ARKE_IDLE;
                    end else begin
                        r_zidx <= r_zidx + 1'b1;
                    end
                end
`endif
                default: r_state <= ARKE_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == ARKE_IDLE) && !rst;
    assign o_out_valid = (r_state == ARKE_DONE);
    assign o_out_state = r_work;
    assign o_out_err   = r_err;
    assign o_busy      = (r_state != ARKE_IDLE);

endmodule
`default_nettype wire
